regfile_golden_checker: RTL and testbench
=========================================

REGFILE_GOLDEN_CHECKER -- requirements
Module: regfile_golden_checker

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 16, meaning the number of architectural registers checked.
REQ-002 The block SHALL have parameter DATA_W, default 16, meaning the register width in bits.
REQ-003 The block SHALL have parameter RUN_CYCLES, default 100, meaning the clocks counted from start before checking begins (min 1).
REQ-004 The block SHALL have derived constant ADDR_W = clog2(NUM_REGS), min 1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-007 start  input  1  one-cycle pulse that launches a run; honoured only in IDLE or DONE.
REQ-008 gold_we  input  1  golden-table write strobe.
REQ-009 gold_addr  input  ADDR_W  golden-table entry index.
REQ-010 gold_data  input  DATA_W  expected register value.
REQ-011 gold_care  input  1  1 = entry is checked; 0 = don't-care.
REQ-012 flags_exp  input  3  expected {N,Z,V}, sampled on accepted start.
REQ-013 flags_mask  input  3  per-flag check enable, sampled on accepted start.
REQ-014 rf_addr  output  ADDR_W  register-file read address driven to the DUT.
REQ-015 rf_data  input  DATA_W  register-file read data, valid one cycle after rf_addr.
REQ-016 flags_in  input  3  live DUT {N,Z,V}.
REQ-017 busy  output  1  high in RUN, SCAN and FLAGS.
REQ-018 done  output  1  high in DONE.
REQ-019 pass  output  1  valid while done; 1 = no mismatch.
REQ-020 fail_cnt  output  ADDR_W+2  count of mismatching registers plus mismatching flag group.
REQ-021 first_fail  output  ADDR_W+1  index of first failing register; NUM_REGS = flags failed; all-ones = none.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, SCAN, FLAGS, DONE.
REQ-023 IDLE/DONE + start: go to RUN, clear cycle counter, fail_cnt and pass; set first_fail to all-ones; latch flags_exp/mask.
REQ-024 RUN SHALL increment the cycle counter each clock and enter SCAN on the clock it reaches RUN_CYCLES-1.
REQ-025 SCAN SHALL drive rf_addr = 0..NUM_REGS-1, one per clock, and compare rf_data one clock later against the golden entry of that issued address.
REQ-026 A compare with gold_care=1 and rf_data != gold_data SHALL increment fail_cnt; the first such compare SHALL load first_fail.
REQ-027 After the last compare (NUM_REGS+1 clocks in SCAN), the FSM SHALL enter FLAGS.
REQ-028 FLAGS SHALL take one clock; a mismatch is ((flags_in XOR flags_exp) AND flags_mask) != 0, incrementing fail_cnt once and loading first_fail = NUM_REGS if still all-ones.
REQ-029 DONE SHALL hold pass = (fail_cnt == 0) and all results stable until the next accepted start.
REQ-030 start in RUN, SCAN or FLAGS SHALL be ignored.
REQ-031 gold_we SHALL write the table only in IDLE or DONE; it is ignored otherwise; an out-of-range gold_addr is ignored.
REQ-032 gold_we and start in the same clock: the write SHALL complete and be visible to the launched run.
REQ-033 fail_cnt SHALL saturate at all-ones.
REQ-034 rf_addr SHALL be 0 outside SCAN.

Reset
REQ-035 rst_n low SHALL immediately force IDLE, busy=0, done=0, pass=0, fail_cnt=0, first_fail=all-ones, rf_addr=0, cycle counter=0, from any state including mid-scan.
REQ-036 Golden-table entries SHALL reset to data 0, care 0.

Structure
REQ-037 A shared package SHALL hold the state enum and the encoded flag bit positions (N=2, Z=1, V=0).
REQ-038 The golden table SHALL be one sub-module, golden_table: synchronous write, combinational read, NUM_REGS x (DATA_W+1).

Verification
REQ-039 Defaults; gold R0=0000, R1=AA05, R3=0057, R4=0057, R15=000F (care); DUT matches; flags masked -> done after 100+17+1 clocks, pass=1, fail_cnt=0, first_fail=all-ones.
REQ-040 As REQ-039, but DUT R1=AAAA -> pass=0, fail_cnt=1, first_fail=1.
REQ-041 R3 and R15 wrong, flags_mask=111, flags_exp=010, flags_in=000 -> fail_cnt=3, first_fail=3.
REQ-042 All registers correct, flags_mask=100, flags_exp=100, flags_in=000 -> fail_cnt=1, first_fail=16.
REQ-043 rst_n low mid-SCAN, then start -> outputs return to reset values; the new run completes normally.
REQ-044 start and gold_we during RUN -> both ignored; the result uses the old table and completes on the original schedule.

Source files
------------

// File: rtl/regfile_golden_checker_pkg.sv
// Shared types for the register-file golden checker: FSM state encoding and
// the bit positions of the {N,Z,V} flag group.
package regfile_golden_checker_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StRun,
      StScan,
      StFlags,
      StDone
   } state_e;

   localparam int unsigned FlagsW = 3;
   localparam int unsigned FlagN  = 2;
   localparam int unsigned FlagZ  = 1;
   localparam int unsigned FlagV  = 0;

   // A flag group mismatches when any enabled bit differs from expectation.
   function automatic logic flags_mismatch(input logic [FlagsW-1:0] live,
                                           input logic [FlagsW-1:0] expected,
                                           input logic [FlagsW-1:0] mask);
      return |((live ^ expected) & mask);
   endfunction

endpackage

// File: rtl/golden_table.sv
// Golden register table: one {care, data} entry per architectural register,
// synchronous write, combinational read. Out-of-range accesses are ignored / read as 0.
module golden_table #(
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              wcare,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata,
   output logic              rcare
);

   localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

   logic [DATA_W:0] mem_q [NUM_REGS];
   logic            wr_ok;
   logic            rd_ok;
   logic [DATA_W:0] entry;

   assign wr_ok = we && ({1'b0, waddr} < NumRegsW);
   assign rd_ok = {1'b0, raddr} < NumRegsW;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_ok) begin
         mem_q[waddr] <= {wcare, wdata};
      end
   end

   assign entry = rd_ok ? mem_q[raddr] : '0;
   assign rcare = entry[DATA_W];
   assign rdata = entry[DATA_W-1:0];

endmodule

// File: rtl/regfile_golden_checker.sv
// End-of-test checker: waits RUN_CYCLES after start, scans the DUT register file
// against a golden table, then checks the {N,Z,V} flags and reports the result.
module regfile_golden_checker
   import regfile_golden_checker_pkg::*;
#(
   parameter int unsigned NUM_REGS   = 16,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RUN_CYCLES = 100,
   localparam int unsigned ADDR_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              gold_we,
   input  logic [ADDR_W-1:0] gold_addr,
   input  logic [DATA_W-1:0] gold_data,
   input  logic              gold_care,
   input  logic [2:0]        flags_exp,
   input  logic [2:0]        flags_mask,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   input  logic [2:0]        flags_in,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W+1:0] fail_cnt,
   output logic [ADDR_W:0]   first_fail
);

   localparam int unsigned     CntW     = (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;
   localparam logic [CntW-1:0] RunLast  = CntW'(RUN_CYCLES - 1);
   localparam logic [ADDR_W:0] NumRegsW = (ADDR_W + 1)'(NUM_REGS);

   state_e              state_q, state_d;
   logic [CntW-1:0]     cnt_q, cnt_d;
   logic [ADDR_W:0]     idx_q, idx_d;
   logic [ADDR_W:0]     idx_m1;
   logic [ADDR_W+1:0]   fail_cnt_q, fail_cnt_d;
   logic [ADDR_W:0]     first_fail_q, first_fail_d;
   logic                pass_q, pass_d;
   logic [2:0]          fexp_q, fexp_d;
   logic [2:0]          fmask_q, fmask_d;
   logic                table_we;
   logic [DATA_W-1:0]   gold_rdata;
   logic                gold_rcare;
   logic                reg_miss;
   logic                flag_miss;
   logic                idle_or_done;

   assign idle_or_done = (state_q == StIdle) || (state_q == StDone);
   assign table_we     = gold_we && idle_or_done;

   // rf_data in this cycle answers the address issued one cycle earlier.
   assign idx_m1 = idx_q - 1'b1;

   golden_table #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W)
   ) u_golden_table (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (table_we),
      .waddr (gold_addr),
      .wdata (gold_data),
      .wcare (gold_care),
      .raddr (idx_m1[ADDR_W-1:0]),
      .rdata (gold_rdata),
      .rcare (gold_rcare)
   );

   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      idx_d        = idx_q;
      fail_cnt_d   = fail_cnt_q;
      first_fail_d = first_fail_q;
      pass_d       = pass_q;
      fexp_d       = fexp_q;
      fmask_d      = fmask_q;
      reg_miss     = 1'b0;
      flag_miss    = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start) begin
               state_d      = StRun;
               cnt_d        = '0;
               idx_d        = '0;
               fail_cnt_d   = '0;
               first_fail_d = '1;
               pass_d       = 1'b0;
               fexp_d       = flags_exp;
               fmask_d      = flags_mask;
            end
         end
         StRun: begin
            if (cnt_q == RunLast) begin
               state_d = StScan;
               idx_d   = '0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         StScan: begin
            reg_miss = (idx_q != '0) && gold_rcare && (rf_data != gold_rdata);
            if (idx_q == NumRegsW) begin
               state_d = StFlags;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         StFlags: begin
            flag_miss = flags_mismatch(flags_in, fexp_q, fmask_q);
            state_d   = StDone;
         end
         default: state_d = StIdle;
      endcase

      if (reg_miss || flag_miss) begin
         if (fail_cnt_q != '1) begin
            fail_cnt_d = fail_cnt_q + 1'b1;
         end
         // All-ones marks "no failure yet", so only the first miss lands here.
         if (first_fail_q == '1) begin
            first_fail_d = reg_miss ? idx_m1 : NumRegsW;
         end
      end

      if (state_q == StFlags) begin
         pass_d = (fail_cnt_d == '0);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         cnt_q        <= '0;
         idx_q        <= '0;
         fail_cnt_q   <= '0;
         first_fail_q <= '1;
         pass_q       <= 1'b0;
         fexp_q       <= '0;
         fmask_q      <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         fail_cnt_q   <= fail_cnt_d;
         first_fail_q <= first_fail_d;
         pass_q       <= pass_d;
         fexp_q       <= fexp_d;
         fmask_q      <= fmask_d;
      end
   end

   assign rf_addr    = ((state_q == StScan) && (idx_q < NumRegsW)) ? idx_q[ADDR_W-1:0] : '0;
   assign busy       = (state_q == StRun) || (state_q == StScan) || (state_q == StFlags);
   assign done       = (state_q == StDone);
   assign pass       = pass_q;
   assign fail_cnt   = fail_cnt_q;
   assign first_fail = first_fail_q;

endmodule

// File: tb/tb_regfile_golden_checker.sv
// Directed bench for regfile_golden_checker with default parameters; a small
// register-file model answers rf_addr one clock later.
module tb_regfile_golden_checker;
   import regfile_golden_checker_pkg::*;

   localparam int Lat = 100 + 16 + 2;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        gold_we;
   logic [3:0]  gold_addr;
   logic [15:0] gold_data;
   logic        gold_care;
   logic [2:0]  flags_exp;
   logic [2:0]  flags_mask;
   logic [3:0]  rf_addr;
   logic [15:0] rf_data;
   logic [2:0]  flags_in;
   logic        busy;
   logic        done;
   logic        pass;
   logic [5:0]  fail_cnt;
   logic [4:0]  first_fail;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;
   int t0    = 0;
   logic [15:0] dut_regs [16];

   regfile_golden_checker dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .gold_we    (gold_we),
      .gold_addr  (gold_addr),
      .gold_data  (gold_data),
      .gold_care  (gold_care),
      .flags_exp  (flags_exp),
      .flags_mask (flags_mask),
      .rf_addr    (rf_addr),
      .rf_data    (rf_data),
      .flags_in   (flags_in),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .fail_cnt   (fail_cnt),
      .first_fail (first_fail)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) rf_data <= dut_regs[rf_addr];

   task automatic gold_write(input logic [3:0] a, input logic [15:0] d, input logic c);
      @(negedge clk);
      gold_we = 1'b1; gold_addr = a; gold_data = d; gold_care = c;
      @(negedge clk);
      gold_we = 1'b0;
   endtask

   task automatic load_table();
      gold_write(4'd0,  16'h0000, 1'b1);
      gold_write(4'd1,  16'hAA05, 1'b1);
      gold_write(4'd3,  16'h0057, 1'b1);
      gold_write(4'd4,  16'h0057, 1'b1);
      gold_write(4'd15, 16'h000F, 1'b1);
   endtask

   task automatic good_dut();
      for (int i = 0; i < 16; i++) dut_regs[i] = 16'hD000 | 16'(i);
      dut_regs[0] = 16'h0000; dut_regs[1] = 16'hAA05; dut_regs[3] = 16'h0057;
      dut_regs[4] = 16'h0057; dut_regs[15] = 16'h000F;
   endtask

   task automatic launch(input logic [2:0] fe, input logic [2:0] fm);
      @(negedge clk);
      flags_exp = fe; flags_mask = fm; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      t0 = cyc;
   endtask

   task automatic wait_done(output int lat);
      while (done !== 1'b1 && (cyc - t0) < 1000) @(negedge clk);
      lat = cyc - t0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done: got %b want 0", done); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL rst_pass: got %b want 0", pass); end
      n_cmp++; if (fail_cnt !== 6'd0) begin n_bad++; $display("FAIL rst_fail_cnt: got %0d want 0", fail_cnt); end
      n_cmp++; if (first_fail !== 5'h1F) begin n_bad++; $display("FAIL rst_first_fail: got %0h want 1f", first_fail); end
      n_cmp++; if (rf_addr !== 4'd0) begin n_bad++; $display("FAIL rst_rf_addr: got %0d want 0", rf_addr); end
   endtask

   task automatic test_all_match();
      int lat;
      good_dut();
      load_table();
      flags_in = 3'b101;
      launch(3'b000, 3'b000);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL match_busy: got %b want 1", busy); end
      wait_done(lat);
      n_cmp++; if (lat !== Lat) begin n_bad++; $display("FAIL match_latency: got %0d want %0d", lat, Lat); end
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL match_pass: got %b want 1", pass); end
      n_cmp++; if (fail_cnt !== 6'd0) begin n_bad++; $display("FAIL match_fail_cnt: got %0d want 0", fail_cnt); end
      n_cmp++; if (first_fail !== 5'h1F) begin n_bad++; $display("FAIL match_first_fail: got %0h want 1f", first_fail); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL match_busy_done: got %b want 0", busy); end
      repeat (5) @(negedge clk);
      n_cmp++; if (done !== 1'b1 || pass !== 1'b1) begin
         n_bad++; $display("FAIL match_hold: got done=%b pass=%b want 1 1", done, pass);
      end
   endtask

   task automatic test_one_wrong();
      int lat;
      dut_regs[1] = 16'hAAAA;
      launch(3'b000, 3'b000);
      wait_done(lat);
      n_cmp++; if (lat !== Lat) begin n_bad++; $display("FAIL one_latency: got %0d want %0d", lat, Lat); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL one_pass: got %b want 0", pass); end
      n_cmp++; if (fail_cnt !== 6'd1) begin n_bad++; $display("FAIL one_fail_cnt: got %0d want 1", fail_cnt); end
      n_cmp++; if (first_fail !== 5'd1) begin n_bad++; $display("FAIL one_first_fail: got %0d want 1", first_fail); end
      dut_regs[1] = 16'hAA05;
   endtask

   task automatic test_dont_care();
      int lat;
      gold_write(4'd1, 16'hAA05, 1'b0);
      dut_regs[1] = 16'hAAAA;
      launch(3'b000, 3'b000);
      wait_done(lat);
      n_cmp++; if (pass !== 1'b1 || fail_cnt !== 6'd0) begin
         n_bad++; $display("FAIL dontcare: got pass=%b cnt=%0d want 1 0", pass, fail_cnt);
      end
      gold_write(4'd1, 16'hAA05, 1'b1);
      dut_regs[1] = 16'hAA05;
   endtask

   task automatic test_multi_fail();
      int lat;
      logic [2:0] fe;
      fe = 3'b000; fe[FlagZ] = 1'b1;
      dut_regs[3] = 16'h0056; dut_regs[15] = 16'h00F0;
      flags_in = 3'b000;
      launch(fe, 3'b111);
      wait_done(lat);
      n_cmp++; if (fail_cnt !== 6'd3) begin n_bad++; $display("FAIL multi_fail_cnt: got %0d want 3", fail_cnt); end
      n_cmp++; if (first_fail !== 5'd3) begin n_bad++; $display("FAIL multi_first_fail: got %0d want 3", first_fail); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL multi_pass: got %b want 0", pass); end
      dut_regs[3] = 16'h0057; dut_regs[15] = 16'h000F;
   endtask

   task automatic test_flags_only();
      int lat;
      logic [2:0] fe;
      fe = 3'b000; fe[FlagN] = 1'b1;
      flags_in = 3'b000;
      launch(fe, fe);
      wait_done(lat);
      n_cmp++; if (fail_cnt !== 6'd1) begin n_bad++; $display("FAIL flags_fail_cnt: got %0d want 1", fail_cnt); end
      n_cmp++; if (first_fail !== 5'd16) begin n_bad++; $display("FAIL flags_first_fail: got %0d want 16", first_fail); end
      n_cmp++; if (pass !== 1'b0) begin n_bad++; $display("FAIL flags_pass: got %b want 0", pass); end
   endtask

   task automatic test_start_during_run();
      int lat;
      launch(3'b000, 3'b000);
      repeat (10) @(negedge clk);
      start = 1'b1; gold_we = 1'b1; gold_addr = 4'd3; gold_data = 16'h1234; gold_care = 1'b1;
      @(negedge clk);
      start = 1'b0; gold_we = 1'b0;
      repeat (95) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat);
      n_cmp++; if (lat !== Lat) begin n_bad++; $display("FAIL busy_start_latency: got %0d want %0d", lat, Lat); end
      n_cmp++; if (pass !== 1'b1) begin n_bad++; $display("FAIL busy_start_pass: got %b want 1", pass); end
      launch(3'b000, 3'b000);
      wait_done(lat);
      n_cmp++; if (fail_cnt !== 6'd0) begin n_bad++; $display("FAIL busy_we_ignored: got %0d want 0", fail_cnt); end
   endtask

   task automatic test_same_cycle();
      int lat;
      @(negedge clk);
      gold_we = 1'b1; gold_addr = 4'd4; gold_data = 16'h0058; gold_care = 1'b1;
      flags_exp = 3'b000; flags_mask = 3'b000; start = 1'b1;
      @(negedge clk);
      gold_we = 1'b0; start = 1'b0;
      t0 = cyc;
      wait_done(lat);
      n_cmp++; if (lat !== Lat) begin n_bad++; $display("FAIL same_latency: got %0d want %0d", lat, Lat); end
      n_cmp++; if (fail_cnt !== 6'd1) begin n_bad++; $display("FAIL same_fail_cnt: got %0d want 1", fail_cnt); end
      n_cmp++; if (first_fail !== 5'd4) begin n_bad++; $display("FAIL same_first_fail: got %0d want 4", first_fail); end
      gold_write(4'd4, 16'h0057, 1'b1);
   endtask

   task automatic test_reset_mid_scan();
      int lat;
      dut_regs[1] = 16'hAAAA;
      launch(3'b000, 3'b000);
      repeat (106) @(negedge clk);
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL scan_busy: got %b want 1", busy); end
      n_cmp++; if (rf_addr !== 4'd6) begin n_bad++; $display("FAIL scan_rf_addr: got %0d want 6", rf_addr); end
      n_cmp++; if (fail_cnt !== 6'd1) begin n_bad++; $display("FAIL scan_fail_cnt: got %0d want 1", fail_cnt); end
      #2 rst_n = 1'b0;
      #1;
      n_cmp++; if (busy !== 1'b0 || done !== 1'b0 || pass !== 1'b0) begin
         n_bad++; $display("FAIL midrst_ctrl: got busy=%b done=%b pass=%b want 0 0 0", busy, done, pass);
      end
      n_cmp++; if (fail_cnt !== 6'd0) begin n_bad++; $display("FAIL midrst_fail_cnt: got %0d want 0", fail_cnt); end
      n_cmp++; if (first_fail !== 5'h1F) begin n_bad++; $display("FAIL midrst_first_fail: got %0h want 1f", first_fail); end
      n_cmp++; if (rf_addr !== 4'd0) begin n_bad++; $display("FAIL midrst_rf_addr: got %0d want 0", rf_addr); end
      @(negedge clk);
      rst_n = 1'b1;
      // Table is cleared by reset, so the wrong R1 is now a don't-care.
      launch(3'b000, 3'b000);
      wait_done(lat);
      n_cmp++; if (lat !== Lat) begin n_bad++; $display("FAIL postrst_latency: got %0d want %0d", lat, Lat); end
      n_cmp++; if (pass !== 1'b1 || fail_cnt !== 6'd0) begin
         n_bad++; $display("FAIL postrst_result: got pass=%b cnt=%0d want 1 0", pass, fail_cnt);
      end
      dut_regs[1] = 16'hAA05;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; gold_we = 1'b0; gold_addr = '0; gold_data = '0;
      gold_care = 1'b0; flags_exp = '0; flags_mask = '0; flags_in = '0;
      good_dut();
      test_reset();
      test_all_match();
      test_one_wrong();
      test_dont_care();
      test_multi_fail();
      test_flags_only();
      test_start_during_run();
      test_same_cycle();
      test_reset_mid_scan();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
